// File: rtl/mold_hdr_front.sv
// MoldUDP64 header front end: decodes the 20-byte header spread over the first
// three 64-bit beats, reports per-beat byte counts and converts lengths to masks.
module mold_hdr_front #(
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int unsigned ML_W       = 16,
    parameter int unsigned KEEP_LW    = $clog2(AXI_KEEP_W) + 1
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  axis_tvalid_i,
    input  logic [AXI_KEEP_W-1:0] axis_tkeep_i,
    input  logic [AXI_DATA_W-1:0] axis_tdata_i,
    input  logic                  axis_tlast_i,
    output logic                  axis_tready_o,
    input  logic [KEEP_LW-1:0]    len_i,
    output logic [AXI_KEEP_W-1:0] mask_o,
    output logic [KEEP_LW-1:0]    data_len_o,
    output logic                  data_len_v_o,
    output logic                  keep_err_o,
    output logic                  sid_v_o,
    output logic [79:0]           sid_o,
    output logic                  seq_v_o,
    output logic [63:0]           seq_o,
    output logic [ML_W-1:0]       msg_cnt_o,
    output logic [ML_W-1:0]       first_len_o,
    output logic                  hdr_err_o
);

    typedef enum logic [1:0] {IDLE, HDR1, HDR2, BODY} state_t;

    state_t                  state, state_nxt;
    logic [AXI_DATA_W-1:0]   data_be;
    logic [63:0]             sid_hi;
    logic [47:0]             seq_hi;
    logic                    ld_sid_hi, sid_done, seq_done, hdr_err_set;
    logic [KEEP_LW-1:0]      keep_cnt;
    logic                    keep_bad;

    function automatic logic [KEEP_LW-1:0] ones_run(input logic [AXI_KEEP_W-1:0] k);
        logic [KEEP_LW-1:0] c;
        logic               run;
        c   = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < AXI_KEEP_W; i++) begin
            run = run & k[i];
            if (run) c = c + KEEP_LW'(1);
        end
        return c;
    endfunction

    function automatic logic [AXI_KEEP_W-1:0] len_to_mask(input logic [KEEP_LW-1:0] len);
        logic [AXI_KEEP_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < AXI_KEEP_W; i++) begin
            m[i] = (i < 32'(len));
        end
        return m;
    endfunction

    assign axis_tready_o = 1'b1;

    // Wire byte 0 lands in the MSB so header fields can be sliced big-endian.
    always_comb begin
        data_be  = {<<8{axis_tdata_i}};
        keep_cnt = ones_run(axis_tkeep_i);
        keep_bad = (axis_tkeep_i != len_to_mask(keep_cnt));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (axis_tvalid_i) begin
            unique case (state)
                IDLE:    state_nxt = axis_tlast_i ? IDLE : HDR1;
                HDR1:    state_nxt = axis_tlast_i ? IDLE : HDR2;
                HDR2:    state_nxt = axis_tlast_i ? IDLE : BODY;
                BODY:    state_nxt = axis_tlast_i ? IDLE : BODY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ld_sid_hi   = axis_tvalid_i && (state == IDLE);
        sid_done    = axis_tvalid_i && (state == HDR1);
        seq_done    = axis_tvalid_i && (state == HDR2);
        hdr_err_set = axis_tvalid_i && axis_tlast_i && ((state == IDLE) || (state == HDR1));
    end

    // Partial fields live in sid_hi/seq_hi so the outputs keep the previous packet until complete.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sid_hi       <= '0;
            seq_hi       <= '0;
            sid_o        <= '0;
            seq_o        <= '0;
            msg_cnt_o    <= '0;
            first_len_o  <= '0;
            sid_v_o      <= 1'b0;
            seq_v_o      <= 1'b0;
            hdr_err_o    <= 1'b0;
            data_len_o   <= '0;
            data_len_v_o <= 1'b0;
            keep_err_o   <= 1'b0;
            mask_o       <= '0;
        end else begin
            sid_v_o      <= sid_done;
            seq_v_o      <= seq_done;
            hdr_err_o    <= hdr_err_set;
            data_len_v_o <= axis_tvalid_i;
            mask_o       <= len_to_mask(len_i);
            if (axis_tvalid_i) begin
                data_len_o <= keep_cnt;
                keep_err_o <= keep_bad;
            end
            if (ld_sid_hi) sid_hi <= data_be[63:0];
            if (sid_done) begin
                sid_o  <= {sid_hi, data_be[63:48]};
                seq_hi <= data_be[47:0];
            end
            if (seq_done) begin
                seq_o       <= {seq_hi, data_be[63:48]};
                msg_cnt_o   <= ML_W'(data_be[47:32]);
                first_len_o <= ML_W'(data_be[31:16]);
            end
        end
    end

endmodule

// File: tb/tb_mold_hdr_front.sv
// Scoreboard bench for mold_hdr_front: driver queues timed expectations, monitor matches DUT pulses.
module tb_mold_hdr_front;

    logic        clk;
    logic        nreset;
    logic        axis_tvalid_i;
    logic [7:0]  axis_tkeep_i;
    logic [63:0] axis_tdata_i;
    logic        axis_tlast_i;
    logic        axis_tready_o;
    logic [3:0]  len_i;
    logic [7:0]  mask_o;
    logic [3:0]  data_len_o;
    logic        data_len_v_o;
    logic        keep_err_o;
    logic        sid_v_o;
    logic [79:0] sid_o;
    logic        seq_v_o;
    logic [63:0] seq_o;
    logic [15:0] msg_cnt_o;
    logic [15:0] first_len_o;
    logic        hdr_err_o;

    mold_hdr_front #(
        .AXI_DATA_W(64),
        .AXI_KEEP_W(8),
        .ML_W(16),
        .KEEP_LW(4)
    ) dut (
        .clk(clk), .nreset(nreset),
        .axis_tvalid_i(axis_tvalid_i), .axis_tkeep_i(axis_tkeep_i),
        .axis_tdata_i(axis_tdata_i), .axis_tlast_i(axis_tlast_i),
        .axis_tready_o(axis_tready_o),
        .len_i(len_i), .mask_o(mask_o),
        .data_len_o(data_len_o), .data_len_v_o(data_len_v_o), .keep_err_o(keep_err_o),
        .sid_v_o(sid_v_o), .sid_o(sid_o),
        .seq_v_o(seq_v_o), .seq_o(seq_o), .msg_cnt_o(msg_cnt_o), .first_len_o(first_len_o),
        .hdr_err_o(hdr_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int unsigned due; logic [79:0] sid; } sid_e_t;
    typedef struct { int unsigned due; logic [63:0] seq; logic [15:0] cnt; logic [15:0] flen; } seq_e_t;
    typedef struct { int unsigned due; logic [3:0] len; logic kerr; } dl_e_t;
    typedef struct { int unsigned due; logic [7:0] mask; } mk_e_t;

    sid_e_t      sid_q[$];
    seq_e_t      seq_q[$];
    dl_e_t       dl_q[$];
    mk_e_t       mk_q[$];
    int unsigned err_q[$];

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // ---------------- driver helpers ----------------
    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                        input logic [3:0] el, input logic ek);
        dl_e_t e;
        @(negedge clk);
        axis_tvalid_i = 1'b1;
        axis_tdata_i  = d;
        axis_tkeep_i  = k;
        axis_tlast_i  = l;
        e.due = cyc + 1; e.len = el; e.kerr = ek;
        dl_q.push_back(e);
    endtask

    // Idle cycle with junk on the bus; it must be ignored.
    task automatic bubble();
        @(negedge clk);
        axis_tvalid_i = 1'b0;
        axis_tdata_i  = '1;
        axis_tkeep_i  = 8'h05;
        axis_tlast_i  = 1'b1;
    endtask

    task automatic exp_sid(input logic [79:0] s);
        sid_e_t e;
        e.due = cyc + 1; e.sid = s;
        sid_q.push_back(e);
    endtask

    task automatic exp_seq(input logic [63:0] s, input logic [15:0] c, input logic [15:0] f);
        seq_e_t e;
        e.due = cyc + 1; e.seq = s; e.cnt = c; e.flen = f;
        seq_q.push_back(e);
    endtask

    task automatic exp_err();
        err_q.push_back(cyc + 1);
    endtask

    task automatic set_len(input logic [3:0] l, input logic [7:0] m);
        mk_e_t e;
        @(negedge clk);
        len_i = l;
        e.due = cyc + 1; e.mask = m;
        mk_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " sid_v"},      80'(sid_v_o), 80'(0));
        chk({tag, " seq_v"},      80'(seq_v_o), 80'(0));
        chk({tag, " hdr_err"},    80'(hdr_err_o), 80'(0));
        chk({tag, " dl_v"},       80'(data_len_v_o), 80'(0));
        chk({tag, " keep_err"},   80'(keep_err_o), 80'(0));
        chk({tag, " data_len"},   80'(data_len_o), 80'(0));
        chk({tag, " sid"},        sid_o, 80'(0));
        chk({tag, " seq"},        80'(seq_o), 80'(0));
        chk({tag, " msg_cnt"},    80'(msg_cnt_o), 80'(0));
        chk({tag, " first_len"},  80'(first_len_o), 80'(0));
        chk({tag, " mask"},       80'(mask_o), 80'(0));
    endtask

    localparam logic [63:0] H1_B0 = 64'h0706050403020100;
    localparam logic [63:0] H1_B1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] H1_B2 = 64'hBBAA0A0003001110;
    localparam logic [79:0] H1_SID = 80'h00010203040506070809;
    localparam logic [63:0] H1_SEQ = 64'h0A0B0C0D0E0F1011;

    localparam logic [63:0] H2_B0 = 64'h8877665544332211;
    localparam logic [63:0] H2_B1 = 64'hF0DEBC9A78563412;
    localparam logic [63:0] H2_B2 = 64'h0000000105000201;
    localparam logic [79:0] H2_SID = 80'h11223344556677881234;
    localparam logic [63:0] H2_SEQ = 64'h56789ABCDEF00102;

    // ---------------- monitor ----------------
    initial begin
        sid_e_t se;
        seq_e_t qe;
        dl_e_t  de;
        mk_e_t  me;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sid_v_o) begin
                if (sid_q.size() > 0 && sid_q[0].due == cyc) begin
                    se = sid_q.pop_front();
                    chk("sid", sid_o, se.sid);
                end else flag("sid_v unexpected");
            end else if (sid_q.size() > 0 && sid_q[0].due <= cyc) begin
                void'(sid_q.pop_front());
                flag("sid_v missing");
            end

            if (seq_v_o) begin
                if (seq_q.size() > 0 && seq_q[0].due == cyc) begin
                    qe = seq_q.pop_front();
                    chk("seq", 80'(seq_o), 80'(qe.seq));
                    chk("msg_cnt", 80'(msg_cnt_o), 80'(qe.cnt));
                    chk("first_len", 80'(first_len_o), 80'(qe.flen));
                end else flag("seq_v unexpected");
            end else if (seq_q.size() > 0 && seq_q[0].due <= cyc) begin
                void'(seq_q.pop_front());
                flag("seq_v missing");
            end

            if (hdr_err_o) begin
                if (err_q.size() > 0 && err_q[0] == cyc) void'(err_q.pop_front());
                else flag("hdr_err unexpected");
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                void'(err_q.pop_front());
                flag("hdr_err missing");
            end

            if (data_len_v_o) begin
                if (dl_q.size() > 0 && dl_q[0].due == cyc) begin
                    de = dl_q.pop_front();
                    chk("data_len", 80'(data_len_o), 80'(de.len));
                    chk("keep_err", 80'(keep_err_o), 80'(de.kerr));
                end else flag("data_len_v unexpected");
            end else if (dl_q.size() > 0 && dl_q[0].due <= cyc) begin
                void'(dl_q.pop_front());
                flag("data_len_v missing");
            end

            if (mk_q.size() > 0 && mk_q[0].due == cyc) begin
                me = mk_q.pop_front();
                chk("mask", 80'(mask_o), 80'(me.mask));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        nreset        = 1'b0;
        axis_tvalid_i = 1'b0;
        axis_tdata_i  = '0;
        axis_tkeep_i  = '0;
        axis_tlast_i  = 1'b0;
        len_i         = 4'd5;
        repeat (3) @(negedge clk);
        check_zero("reset");
        nreset = 1'b1;
        bubble();

        // Back-to-back header, then body beats exercising tkeep counting.
        beat(H1_B0, 8'hFF, 1'b0, 4'd8, 1'b0);
        beat(H1_B1, 8'hFF, 1'b0, 4'd8, 1'b0); exp_sid(H1_SID);
        beat(H1_B2, 8'hFF, 1'b0, 4'd8, 1'b0); exp_seq(H1_SEQ, 16'd3, 16'd10);
        beat(64'h1,  8'h0F, 1'b0, 4'd4, 1'b0);
        beat(64'h2,  8'h01, 1'b0, 4'd1, 1'b0);
        beat(64'h3,  8'h00, 1'b0, 4'd0, 1'b0);
        beat(64'h4,  8'h05, 1'b1, 4'd1, 1'b1);
        bubble();

        // Same header with bubbles; tlast on the final header beat.
        beat(H1_B0, 8'hFF, 1'b0, 4'd8, 1'b0);
        bubble(); bubble();
        beat(H1_B1, 8'hFF, 1'b0, 4'd8, 1'b0); exp_sid(H1_SID);
        bubble();
        beat(H1_B2, 8'hFF, 1'b1, 4'd8, 1'b0); exp_seq(H1_SEQ, 16'd3, 16'd10);
        bubble(); bubble();

        // Length to mask.
        set_len(4'd0,  8'h00);
        set_len(4'd3,  8'h07);
        set_len(4'd8,  8'hFF);
        set_len(4'd12, 8'hFF);
        set_len(4'd7,  8'h7F);
        set_len(4'd1,  8'h01);
        set_len(4'd12, 8'hFF);

        // Short packet, then next beat restarts as beat 0.
        beat(64'hDEADBEEF, 8'hFF, 1'b1, 4'd8, 1'b0); exp_err();
        beat(H2_B0, 8'hFF, 1'b0, 4'd8, 1'b0);
        beat(H2_B1, 8'hFF, 1'b0, 4'd8, 1'b0); exp_sid(H2_SID);
        beat(H2_B2, 8'hFF, 1'b0, 4'd8, 1'b0); exp_seq(H2_SEQ, 16'd5, 16'h0100);
        beat(64'h5, 8'h07, 1'b1, 4'd3, 1'b0);

        // tlast on the second beat: sid completes, header error still flagged.
        beat(H1_B0, 8'hFF, 1'b0, 4'd8, 1'b0);
        beat(H1_B1, 8'hFF, 1'b1, 4'd8, 1'b0); exp_sid(H1_SID); exp_err();
        bubble(); bubble();

        // Reset while in HDR2.
        beat(H2_B0, 8'hFF, 1'b0, 4'd8, 1'b0);
        beat(H2_B1, 8'hFF, 1'b0, 4'd8, 1'b0); exp_sid(H2_SID);
        @(negedge clk);
        axis_tvalid_i = 1'b0;
        nreset        = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        beat(H1_B0, 8'hFF, 1'b0, 4'd8, 1'b0);
        beat(H1_B1, 8'hFF, 1'b0, 4'd8, 1'b0); exp_sid(H1_SID);
        beat(H1_B2, 8'hFF, 1'b1, 4'd8, 1'b0); exp_seq(H1_SEQ, 16'd3, 16'd10);
        repeat (4) bubble();

        chk("sid_q drained",  80'(sid_q.size()), 80'(0));
        chk("seq_q drained",  80'(seq_q.size()), 80'(0));
        chk("err_q drained",  80'(err_q.size()), 80'(0));
        chk("dl_q drained",   80'(dl_q.size()), 80'(0));
        chk("mask_q drained", 80'(mk_q.size()), 80'(0));
        chk("tready", 80'(axis_tready_o), 80'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mold_hdr_front.md
Name: mold_hdr_front

Overview:
Front-end decoder for MoldUDP64 packets arriving on a 64-bit AXI-stream from the UDP stack. It tracks the 20-byte header across the first three beats and extracts Session ID, Sequence Number, Message Count and the first message length. For each beat it reports the valid byte count from tkeep. It also provides a length-to-byte-mask conversion used by downstream message assembly. Internally it is built from three sub-functions: tkeep ones counter, header field extractor and length-to-mask.

Parameters:
AXI_DATA_W, 64, stream data width in bits (fixed at 64 for header byte positions)
AXI_KEEP_W, 8, tkeep width (AXI_DATA_W/8)
ML_W, 16, message length / message count field width
KEEP_LW, 4, byte-count width ($clog2(AXI_KEEP_W)+1)

Ports:
clk  in  1  clock, rising edge
nreset  in  1  asynchronous active-low reset
axis_tvalid_i  in  1  beat valid
axis_tkeep_i  in  AXI_KEEP_W  byte enables; byte i at tdata[8i+7:8i]
axis_tdata_i  in  AXI_DATA_W  beat data; byte 0 of beat in [7:0]
axis_tlast_i  in  1  last beat of UDP payload
axis_tready_o  out  1  constant 1
len_i  in  KEEP_LW  byte length to convert to mask
mask_o  out  AXI_KEEP_W  registered mask of len_i
data_len_o  out  KEEP_LW  registered valid-byte count of last accepted beat
data_len_v_o  out  1  data_len_o valid
keep_err_o  out  1  last accepted tkeep was not a thermometer code
sid_v_o  out  1  one-cycle pulse, sid_o valid
sid_o  out  80  Session ID, wire byte 0 in [79:72]
seq_v_o  out  1  one-cycle pulse, seq_o and msg_cnt_o valid
seq_o  out  64  Sequence Number, big-endian to numeric value
msg_cnt_o  out  ML_W  Message Count, big-endian to numeric value
first_len_o  out  ML_W  first message length, big-endian to numeric value
hdr_err_o  out  1  one-cycle pulse: tlast arrived before header completed

Behaviour:
- Beat accepted when axis_tvalid_i=1 at posedge (tready tied 1). Beats with tvalid=0 are ignored and leave state unchanged.
- All outputs are registered, with one-cycle latency from the accepted beat.
- Reset (async, nreset=0): state IDLE. All valids, hdr_err_o and keep_err_o=0. All data outputs=0. mask_o=0. Reset mid-packet drops the packet; decoding restarts at the next beat as beat 0.
- FSM states: IDLE, HDR1, HDR2, BODY.
  - IDLE: accepted beat is beat 0. Stores stream bytes 0-7 as sid[79:16]. Go to HDR1.
  - HDR1: bytes 8-9 complete sid (sid_o=full 80 bits, sid_v_o pulse). Bytes 10-15 are stored as seq bytes 0-5. Go to HDR2.
  - HDR2: beat bytes 0-1 (stream bytes 16-17) complete seq.
    - msg_cnt = {byte2, byte3}; first_len = {byte4, byte5}.
    - seq_v_o pulses. Go to BODY, or to IDLE if tlast.
  - BODY: stays until an accepted beat has tlast, then goes to IDLE.
- tlast accepted in IDLE or HDR1: hdr_err_o pulses, state goes to IDLE, and no sid_v/seq_v pulse is produced for the incomplete header. Exception: sid_v_o still pulses if the tlast beat was the HDR1 beat, since sid is complete.
- Field outputs hold their value until overwritten by the next packet.
- data_len_o: count of contiguous ones in tkeep starting at bit 0, range 0..8. Updated on every accepted beat; data_len_v_o=1 the following cycle.
  - keep_err_o=1 if tkeep has any 1 above the first 0 (e.g. 0x05 gives count 1, err 1).
  - tkeep=0 gives count 0, err 0.
- mask_o is registered every cycle: bits [len_i-1:0]=1, others 0. len_i=0 gives 0x00; len_i>=8 gives 0xFF.

Test Plan:
- Header decode. Three beats, tkeep=0xFF:
  - 0x0706050403020100, then 0x0F0E0D0C0B0A0908, then 0xBBAA0A0003001110.
  - Expect sid_v_o pulse with sid_o=0x00010203040506070809.
  - Next cycle expect seq_v_o with seq_o=0x08090A0B0C0D0E0F1011 truncated to bytes 10-17, i.e. 0x0A0B0C0D0E0F1011. Also msg_cnt_o=3 and first_len_o=10.
- Bubbles: same packet with tvalid=0 cycles inserted between beats -> identical field values; pulses delayed accordingly.
- tkeep counting:
  - tkeep 0xFF gives data_len 8; 0x0F gives 4; 0x01 gives 1; 0x00 gives 0. All with keep_err=0.
  - tkeep 0x05 gives data_len 1 with keep_err=1.
- Length to mask:
  - len_i 0, 3, 8 and 12 give mask_o 0x00, 0x07, 0xFF and 0xFF one cycle later.
- Short packet: beat 0 with tlast=1 -> hdr_err_o pulse, no sid_v/seq_v, next beat is decoded as beat 0.
- Reset mid-operation: assert nreset=0 in HDR2 -> all outputs 0 immediately. After release, a full 3-beat header decodes correctly.
